pla_decode_capture: RTL and testbench
=====================================

PLA_DECODE_CAPTURE -- requirements
Module: pla_decode_capture

Interface
REQ-001 Parameter WIDTH, default 94: width of the decoded control word from the decode PLA (outputs z00..z93, bit i = zNN).
REQ-002 Parameter ONEHOT_LSB, default 38: lowest bit of the 8-bit one-hot group checked for conflicts (bits 45:38).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  decoded control word from the PLA.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 out_data  output  WIDTH  head-of-buffer control word.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 err_clr  input  1  clears the sticky conflict flag.
REQ-012 err_sticky  output  1  a one-hot conflict was captured since the last clear.
REQ-013 xfer_cnt  output  16  count of completed output transfers.
REQ-014 out_par  output  1  even parity of out_data (present only with the macro of REQ-032).

Function
REQ-015 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated in the same cycle.
REQ-016 Storage is a 2-entry FIFO (entries, 1-bit write pointer, 1-bit read pointer, 2-bit occupancy count 0..2).
REQ-017 in_ready = (count != 2); combinational from registered count only, never from out_ready.
REQ-018 out_valid = (count != 0); out_data = entry at read pointer; both registered-state-driven, no in-to-out combinational path.
REQ-019 Latency: a word pushed in cycle N appears on out_data with out_valid in cycle N+1 when the buffer was empty.
REQ-020 Count 0, push only -> 1; count 1, push and pop -> stays 1, order preserved; count 2 -> no push possible, pop -> 1.
REQ-021 Pop with count 0 cannot occur (out_valid low); out_ready while empty has no effect.
REQ-022 Pointers wrap 1 -> 0; FIFO order is strict first-in first-out.
REQ-023 out_data holds stable while out_valid high and out_ready low.
REQ-024 On push, popcount of in_data[ONEHOT_LSB+7:ONEHOT_LSB] > 1 sets err_sticky next cycle; 0 or 1 set bits are legal.
REQ-025 err_clr clears err_sticky next cycle; err_clr and a conflicting push in the same cycle -> err_sticky = 1 (set wins).
REQ-026 Conflicting words are still buffered and forwarded unchanged.
REQ-027 xfer_cnt increments by 1 on each pop, wraps 0xFFFF -> 0x0000.

Reset
REQ-028 While rst high: count = 0, pointers = 0, err_sticky = 0, xfer_cnt = 0, out_valid = 0, in_ready = 1.
REQ-029 out_data and out_par read 0 during reset (entries cleared).
REQ-030 Reset asserted mid-transfer discards all buffered words; no pop is counted in the reset cycle.
REQ-031 First push accepted on the first rising edge with rst low.

Configuration
REQ-032 Macro PLA_DECODE_CAPTURE_PARITY_EN: when defined, each entry stores an extra parity bit computed as XOR of in_data at push, and out_par presents the head entry's stored bit.
REQ-033 Without PLA_DECODE_CAPTURE_PARITY_EN: no parity storage, out_par port absent; all other behaviour identical.

Verification
REQ-034 Reset, then push 0x1 with out_ready=0 -> next cycle out_valid=1, out_data=0x1, in_ready=1; push 0x2 -> count 2, in_ready=0.
REQ-035 Full buffer {0x1,0x2}, in_valid=1 with 0x3, out_ready=1 for 3 cycles -> outputs 0x1, 0x2, 0x3 in order, xfer_cnt=3.
REQ-036 Push word with bits 38 and 41 set -> err_sticky=1 next cycle; push with bit 40 only plus err_clr -> err_sticky=0; err_clr with conflicting push -> err_sticky stays 1.
REQ-037 Preload xfer_cnt to 0xFFFF via 65535 pops, one more pop -> xfer_cnt=0x0000.
REQ-038 Two words buffered, assert rst asynchronously between edges -> out_valid=0, in_ready=1, xfer_cnt=0 immediately, no clock edge needed.
REQ-039 With PLA_DECODE_CAPTURE_PARITY_EN, push 0x7 then 0x3 -> out_par=1 then 0.

Source files
------------

// File: rtl/pla_decode_capture.sv
// pla_decode_capture: two-entry skid FIFO that captures decoded PLA control
// words. It flags words whose one-hot group has more than one bit set in a
// sticky error flag, and it counts completed output transfers.
// Optional build macro PLA_DECODE_CAPTURE_PARITY_EN stores a per-entry even
// parity bit and presents the head entry's bit on out_par.
module pla_decode_capture #(
  parameter int WIDTH      = 94,
  parameter int ONEHOT_LSB = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             err_sticky,
  output logic [15:0]      xfer_cnt
`ifdef PLA_DECODE_CAPTURE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;
  logic             conflict;

  // More than one bit set in the one-hot group is an illegal decode.
  function automatic logic onehot_conflict(input logic [7:0] grp);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + int'(grp[i]);
    end
    return (ones > 1);
  endfunction

  // Handshake flags come only from the registered occupancy, so there is no
  // combinational path from the input side to the output side.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];
  assign conflict  = onehot_conflict(in_data[ONEHOT_LSB+7:ONEHOT_LSB]);

  // Entry storage; cleared on reset so out_data reads zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifdef PLA_DECODE_CAPTURE_PARITY_EN
  logic par_mem [2];

  // Parity captured alongside each entry at push time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_mem[0] <= 1'b0;
      par_mem[1] <= 1'b0;
    end else if (push) begin
      par_mem[wr_ptr] <= ^in_data;
    end
  end

  assign out_par = par_mem[rd_ptr];
`endif

  // Pointer and occupancy bookkeeping; 1-bit pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky conflict flag; a conflicting push beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (push && conflict) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  // Completed-transfer counter, wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 16'd0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pla_decode_capture.sv
// Testbench for pla_decode_capture: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pla_decode_capture;

  localparam int W   = 94;
  localparam int LSB = 38;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err_clr;
  logic          err_sticky;
  logic [15:0]   xfer_cnt;
`ifdef PLA_DECODE_CAPTURE_PARITY_EN
  logic          out_par;
`endif

  pla_decode_capture #(.WIDTH(W), .ONEHOT_LSB(LSB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .xfer_cnt   (xfer_cnt)
`ifdef PLA_DECODE_CAPTURE_PARITY_EN
    ,
    .out_par    (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model: a bounded queue of words, a flag and a counter.
  logic [W-1:0] q[$];
  logic         m_err;
  int           m_cnt;

  typedef struct {
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         clr;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_ready;
    logic         e_err;
    int           e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bit_at(input int b);
    logic [W-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [95:0] r;
    logic [W-1:0] w;
    r = {$urandom, $urandom, $urandom};
    w = r[W-1:0];
    case ($urandom_range(0, 3))
      0: w[LSB+7:LSB] = 8'h00;
      1: w[LSB+7:LSB] = 8'h01 << $urandom_range(0, 7);
      default: ;
    endcase
    return w;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endfunction

  // Apply one cycle of inputs (called just after a falling edge), advance
  // the model at the rising edge, then optionally compare at the next fall.
  task automatic step(input logic iv, input logic [W-1:0] din, input logic ordy,
                      input logic clr, input logic do_chk);
    logic         pu;
    logic         po;
    logic [7:0]   grp;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clk);
    pu  = iv && (q.size() < 2);
    po  = (q.size() > 0) && ordy;
    grp = din[LSB+7:LSB];
    if (po) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1) % 65536;
    end
    if (pu) q.push_back(din);
    if (pu && ($countones(grp) > 1)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(negedge clk);
    if (do_chk) begin
      check("out_valid", 128'(out_valid), 128'(q.size() > 0));
      check("in_ready", 128'(in_ready), 128'(q.size() < 2));
      check("err_sticky", 128'(err_sticky), 128'(m_err));
      check("xfer_cnt", 128'(xfer_cnt), 128'(m_cnt));
      if (q.size() > 0) begin
        check("out_data", 128'(out_data), 128'(q[0]));
`ifdef PLA_DECODE_CAPTURE_PARITY_EN
        check("out_par", 128'(out_par), 128'(^q[0]));
`endif
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    in_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_xfer_cnt", 128'(xfer_cnt), 128'(0));
    check("rst_err", 128'(err_sticky), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Directed vectors: expected outputs after the cycle is clocked.
    tbl[0] = '{1'b1, W'(1), 1'b0, 1'b0, 1'b1, W'(1), 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, W'(2), 1'b0, 1'b0, 1'b1, W'(1), 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, W'(3), 1'b1, 1'b0, 1'b1, W'(2), 1'b1, 1'b0, 1};
    tbl[3] = '{1'b1, W'(3), 1'b1, 1'b0, 1'b1, W'(3), 1'b1, 1'b0, 2};
    tbl[4] = '{1'b0, W'(0), 1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b0, 3};
    tbl[5] = '{1'b1, bit_at(38) | bit_at(41), 1'b1, 1'b0, 1'b1,
               bit_at(38) | bit_at(41), 1'b1, 1'b1, 3};
    tbl[6] = '{1'b1, bit_at(40), 1'b1, 1'b1, 1'b1, bit_at(40), 1'b1, 1'b0, 4};
    tbl[7] = '{1'b1, bit_at(39) | bit_at(45), 1'b1, 1'b1, 1'b1,
               bit_at(39) | bit_at(45), 1'b1, 1'b1, 5};
    tbl[8] = '{1'b0, W'(0), 1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b1, 6};
    tbl[9] = '{1'b0, W'(0), 1'b1, 1'b1, 1'b0, W'(0), 1'b1, 1'b0, 6};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].din, tbl[i].ordy, tbl[i].clr, 1'b0);
      check($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(tbl[i].e_valid));
      check($sformatf("vec%0d_ready", i), 128'(in_ready), 128'(tbl[i].e_ready));
      check($sformatf("vec%0d_err", i), 128'(err_sticky), 128'(tbl[i].e_err));
      check($sformatf("vec%0d_cnt", i), 128'(xfer_cnt), 128'(tbl[i].e_cnt));
      if (tbl[i].e_valid)
        check($sformatf("vec%0d_data", i), 128'(out_data), 128'(tbl[i].e_data));
    end

    // Hold: full buffer with consumer stalled keeps the head stable.
    step(1'b1, W'(16'hA5), 1'b0, 1'b0, 1'b1);
    step(1'b1, W'(16'h5A), 1'b0, 1'b0, 1'b1);
    step(1'b1, W'(16'h77), 1'b0, 1'b0, 1'b1);
    check("hold_data", 128'(out_data), 128'(16'hA5));

    // Asynchronous reset between edges with two words buffered.
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid), 128'(0));
    check("arst_ready", 128'(in_ready), 128'(1));
    check("arst_cnt", 128'(xfer_cnt), 128'(0));
    check("arst_data", 128'(out_data), 128'(0));
    model_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First rising edge after release accepts a push.
    step(1'b1, W'(16'h1234), 1'b0, 1'b0, 1'b1);
    check("first_push_data", 128'(out_data), 128'(16'h1234));

`ifdef PLA_DECODE_CAPTURE_PARITY_EN
    do_reset();
    step(1'b1, W'(7), 1'b0, 1'b0, 1'b1);
    check("par_7", 128'(out_par), 128'(1));
    step(1'b1, W'(3), 1'b1, 1'b0, 1'b1);
    check("par_3", 128'(out_par), 128'(0));
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 1'b1);
    end

    // Counter wrap: 65535 pops then one more.
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    end
    check("cnt_ffff", 128'(xfer_cnt), 128'(16'hFFFF));
    step(1'b1, W'(5), 1'b1, 1'b0, 1'b1);
    check("cnt_wrap", 128'(xfer_cnt), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
